des_cbc_output_stage: RTL



---
 rtl/des_pkg.sv | 16 +
 rtl/des_cbc_output_stage_if.sv | 25 ++
 rtl/block_serializer.sv | 57 +++++
 rtl/des_cbc_output_stage.sv | 47 ++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types and sizes for the DES CBC output stage.
package des_pkg;
    localparam int unsigned BLOCK_W         = 64;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned BYTES_PER_BLOCK = 8;
    localparam int unsigned CNT_W           = $clog2(BYTES_PER_BLOCK);

    // Bit 1 is the MSB, matching DES numbering.
    typedef logic [1:BLOCK_W] des_block_t;
    typedef logic [1:BYTE_W]  des_byte_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

// File: rtl/des_cbc_output_stage_if.sv
// Block-in / byte-out handshake bundle; master is the environment, slave is the stage.
interface des_cbc_output_stage_if;
    import des_pkg::*;

    logic       iv_load;
    des_block_t iv;
    logic       in_valid;
    logic       in_ready;
    des_block_t ct;
    des_block_t pt_raw;
    logic       out_valid;
    logic       out_ready;
    des_byte_t  out_byte;
    logic       out_last;

    modport master (
        output iv_load, iv, in_valid, ct, pt_raw, out_ready,
        input  in_ready, out_valid, out_byte, out_last
    );

    modport slave (
        input  iv_load, iv, in_valid, ct, pt_raw, out_ready,
        output in_ready, out_valid, out_byte, out_last
    );
endinterface

// File: rtl/block_serializer.sv
// 64-to-8 shift register presenting a block MSB-first over valid/ready.
module block_serializer
    import des_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  des_block_t load_data,
    input  logic       out_ready,
    output logic       out_valid,
    output des_byte_t  out_byte,
    output logic       out_last,
    output logic       can_load_c
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    des_block_t       shreg_q, shreg_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        out_valid  = (state_q == SEND);
        out_byte   = out_valid ? shreg_q[1:BYTE_W] : '0;
        out_last   = out_valid && (cnt_q == CNT_W'(BYTES_PER_BLOCK - 1));
        // A new block may land on the same edge as the final byte handshake.
        can_load_c = !rst && ((state_q == IDLE) || (out_last && out_ready));

        if (out_valid && out_ready) begin
            shreg_d = shreg_q << BYTE_W;
            if (out_last) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (load) begin
            shreg_d = load_data;
            cnt_d   = '0;
            state_d = SEND;
        end
    end
endmodule

// File: rtl/des_cbc_output_stage.sv
// Undoes CBC chaining on DES core output and streams the plaintext out as bytes.
module des_cbc_output_stage
    import des_pkg::*;
#(
    parameter bit CBC_EN = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    des_cbc_output_stage_if.slave bus
);
    des_block_t chain_q;
    des_block_t ch_eff;
    des_block_t blk_in;
    logic       can_load_c;
    logic       accept;

    always_comb begin
        ch_eff = bus.iv_load ? bus.iv : chain_q;
        blk_in = CBC_EN ? (bus.pt_raw ^ ch_eff) : bus.pt_raw;
        accept = bus.in_valid && can_load_c;
    end

    assign bus.in_ready = can_load_c;

    // Chain register: accepted ciphertext wins over a concurrent IV load.
    always_ff @(posedge clk) begin
        if (rst || !CBC_EN) begin
            chain_q <= '0;
        end else if (accept) begin
            chain_q <= bus.ct;
        end else if (bus.iv_load) begin
            chain_q <= bus.iv;
        end
    end

    block_serializer u_ser (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_data  (blk_in),
        .out_ready  (bus.out_ready),
        .out_valid  (bus.out_valid),
        .out_byte   (bus.out_byte),
        .out_last   (bus.out_last),
        .can_load_c (can_load_c)
    );
endmodule
